// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor, LSB-first, DIGIT_W bits per cycle, LEN digits per word.
// Optional framing check enabled by defining DSA_FRAME_CHECK_EN (adds in_last / frame_err).
module digit_serial_addsub #(
   parameter int unsigned DIGIT_W = 1,
   parameter int unsigned LEN     = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               abort,
   input  logic               in_valid,
   input  logic               sub,
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
`ifdef DSA_FRAME_CHECK_EN
   input  logic               in_last,
   output logic               frame_err,
`endif
   output logic               out_valid,
   output logic [DIGIT_W-1:0] sum,
   output logic               out_last,
   output logic               cout,
   output logic               ovf
);

   localparam int unsigned CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               carry;
   logic               sub_lat;

   logic               accept;
   logic               first;
   logic               last;
   logic               sub_eff;
   logic               c_in;
   logic [DIGIT_W-1:0] b_x;
   logic [DIGIT_W-1:0] s_d;
   logic               c_o;
   logic               c_msb;

   // Digit datapath: first digit takes sub directly, later digits use the latched copy
   always_comb begin
      accept         = in_valid & ~abort;
      first          = (state == IDLE);
      last           = (cnt == CNT_LAST);
      sub_eff        = first ? sub : sub_lat;
      c_in           = first ? sub : carry;
      b_x            = sub_eff ? ~b : b;
      {c_o, s_d}     = {1'b0, a} + {1'b0, b_x} + (DIGIT_W+1)'(c_in);
      // sum bit = a ^ b ^ carry-in, so the carry into the MSB is recoverable from it
      c_msb          = a[DIGIT_W-1] ^ b_x[DIGIT_W-1] ^ s_d[DIGIT_W-1];
   end

   // Framing FSM, carry/sub state and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         carry     <= 1'b0;
         sub_lat   <= 1'b0;
         out_valid <= 1'b0;
         sum       <= '0;
         out_last  <= 1'b0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
`ifdef DSA_FRAME_CHECK_EN
         frame_err <= 1'b0;
`endif
      end else begin
         out_valid <= accept;
         out_last  <= 1'b0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
`ifdef DSA_FRAME_CHECK_EN
         frame_err <= 1'b0;
`endif
         if (abort) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
         end else if (accept) begin
            sum   <= s_d;
            carry <= c_o;
            if (first) sub_lat <= sub;
`ifdef DSA_FRAME_CHECK_EN
            frame_err <= (in_last != last);
`endif
            if (last) begin
               state    <= IDLE;
               cnt      <= '0;
               out_last <= 1'b1;
               cout     <= c_o;
               ovf      <= c_msb ^ c_o;
            end else begin
               state <= RUN;
               cnt   <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: word-level arithmetic model with per-digit scoreboard,
// directed scenarios plus randomized words with gaps, aborts and back-to-back framing.
module tb_digit_serial_addsub;

   localparam int DW = 4;
   localparam int LN = 2;

   typedef struct packed {
      logic [DW-1:0] sum;
      logic          last;
      logic          cout;
      logic          ovf;
      logic          ferr;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          abort = 1'b0, in_valid = 1'b0, sub = 1'b0, in_last = 1'b0;
   logic [DW-1:0] a = '0, b = '0;
   logic          out_valid, out_last, cout, ovf, frame_err;
   logic [DW-1:0] sum;

   logic v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, s1 = 1'b0, ab1 = 1'b0, il1 = 1'b0;
   logic ov1, sum1, ol1, co1, of1, fe1;

   int   n_cmp = 0;
   int   n_bad = 0;
   bit   checking = 1'b0;
   exp_t q[$];
   exp_t ce;

   always #5 clk = ~clk;

   digit_serial_addsub #(.DIGIT_W(DW), .LEN(LN)) dut (
      .clk(clk), .reset_n(reset_n), .abort(abort), .in_valid(in_valid), .sub(sub),
      .a(a), .b(b),
`ifdef DSA_FRAME_CHECK_EN
      .in_last(in_last), .frame_err(frame_err),
`endif
      .out_valid(out_valid), .sum(sum), .out_last(out_last), .cout(cout), .ovf(ovf));

   digit_serial_addsub #(.DIGIT_W(1), .LEN(8)) dut1 (
      .clk(clk), .reset_n(reset_n), .abort(ab1), .in_valid(v1), .sub(s1),
      .a(a1), .b(b1),
`ifdef DSA_FRAME_CHECK_EN
      .in_last(il1), .frame_err(fe1),
`endif
      .out_valid(ov1), .sum(sum1), .out_last(ol1), .cout(co1), .ovf(of1));

`ifndef DSA_FRAME_CHECK_EN
   assign frame_err = 1'b0;
   assign fe1 = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Whole-word result: A + B or A - B as A + ~B + 1, with carry in bit 8
   function automatic logic [8:0] word_res(input logic [7:0] wa, input logic [7:0] wb, input logic ws);
      return {1'b0, wa} + {1'b0, (ws ? ~wb : wb)} + 9'(ws);
   endfunction

   // Signed overflow from operand and result signs
   function automatic logic word_ovf(input logic [7:0] wa, input logic [7:0] wb, input logic ws);
      logic [8:0] r;
      r = word_res(wa, wb, ws);
      if (ws) return (wa[7] != wb[7]) && (r[7] != wa[7]);
      return (wa[7] == wb[7]) && (r[7] != wa[7]);
   endfunction

   task automatic idle_cycle();
      in_valid = 1'b0;
      a        = DW'($urandom);
      b        = DW'($urandom);
      sub      = 1'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
   endtask

   // Drive one word; abort_at >= 0 aborts at that digit position instead of sending it
   task automatic send_word(input logic [7:0] wa, input logic [7:0] wb, input logic ws,
                            input int gmin, input int gmax, input int abort_at);
      logic [8:0] r;
      exp_t       e;
      logic       lst;
      r = word_res(wa, wb, ws);
      for (int d = 0; d < LN; d++) begin
         if (d > 0) begin
            int g;
            g = int'($urandom_range(gmax, gmin));
            for (int k = 0; k < g; k++) idle_cycle();
         end
         if (d == abort_at) begin
            abort    = 1'b1;
            in_valid = 1'($urandom);
            a        = DW'($urandom);
            b        = DW'($urandom);
            @(posedge clk); #1;
            abort    = 1'b0;
            in_valid = 1'b0;
            return;
         end
         lst      = (d == LN - 1);
         in_valid = 1'b1;
         a        = wa[d*DW +: DW];
         b        = wb[d*DW +: DW];
         sub      = (d == 0) ? ws : 1'($urandom);
         in_last  = lst ^ ($urandom_range(7, 0) == 0);
         e.sum    = r[d*DW +: DW];
         e.last   = lst;
         e.cout   = lst ? r[8] : 1'b0;
         e.ovf    = lst ? word_ovf(wa, wb, ws) : 1'b0;
         e.ferr   = (in_last != lst);
         q.push_back(e);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   // Scoreboard: every out_valid must match the oldest expected digit
   always @(negedge clk) begin
      if (checking) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
               ce = q.pop_front();
               chk("sum", 32'(sum), 32'(ce.sum));
               chk("out_last", 32'(out_last), 32'(ce.last));
               chk("cout", 32'(cout), 32'(ce.cout));
               chk("ovf", 32'(ovf), 32'(ce.ovf));
`ifdef DSA_FRAME_CHECK_EN
               chk("frame_err", 32'(frame_err), 32'(ce.ferr));
`endif
            end
         end else begin
            chk("idle_out_last", 32'(out_last), 32'd0);
            chk("idle_cout", 32'(cout), 32'd0);
            chk("idle_ovf", 32'(ovf), 32'd0);
            chk("idle_frame_err", 32'(frame_err), 32'd0);
         end
      end
   end

   initial begin
      // Pin the model with hand-computed words
      chk("model_add_5A_3C", 32'(word_res(8'h5A, 8'h3C, 1'b0)), 32'h096);
      chk("model_ovf_5A_3C", 32'(word_ovf(8'h5A, 8'h3C, 1'b0)), 32'd1);
      chk("model_sub_10_20", 32'(word_res(8'h10, 8'h20, 1'b1)), 32'h0F0);
      chk("model_ovf_10_20", 32'(word_ovf(8'h10, 8'h20, 1'b1)), 32'd0);
      chk("model_sub_80_01", 32'(word_res(8'h80, 8'h01, 1'b1)), 32'h17F);
      chk("model_ovf_80_01", 32'(word_ovf(8'h80, 8'h01, 1'b1)), 32'd1);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_out_valid1", 32'(ov1), 32'd0);
      reset_n  = 1'b1;
      checking = 1'b1;
      @(posedge clk); #1;

      send_word(8'h5A, 8'h3C, 1'b0, 0, 0, -1);
      idle_cycle();
      send_word(8'h10, 8'h20, 1'b1, 0, 0, -1);
      send_word(8'h80, 8'h01, 1'b1, 0, 0, -1);
      idle_cycle();
      send_word(8'h5A, 8'h3C, 1'b0, 3, 3, -1);
      idle_cycle();

      // Reset after first digit of 0xFF+0x01; that digit's output is lost
      in_valid = 1'b1; a = 4'hF; b = 4'h1; sub = 1'b0; in_last = 1'b0;
      @(posedge clk); #1;
      reset_n  = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      send_word(8'h01, 8'h01, 1'b0, 0, 0, -1);
      idle_cycle();

      send_word(8'h5A, 8'h3C, 1'b0, 0, 0, 1);
      send_word(8'h7F, 8'h01, 1'b0, 0, 0, -1);
      idle_cycle();

      for (int w = 0; w < 200; w++) begin
         send_word(8'($urandom), 8'($urandom), 1'($urandom), 0, 2,
                   ($urandom_range(9, 0) == 0) ? int'($urandom_range(LN - 1, 0)) : -1);
         if ($urandom_range(3, 0) == 0) idle_cycle();
      end
      idle_cycle();

      // Bit-serial instance: 0xFF + 0x01
      s1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         v1  = 1'b1;
         a1  = 1'b1;
         b1  = (i == 0);
         il1 = (i == 7);
         @(posedge clk); #1;
         v1 = 1'b0;
         chk("bs_out_valid", 32'(ov1), 32'd1);
         chk("bs_sum", 32'(sum1), 32'd0);
         chk("bs_out_last", 32'(ol1), 32'(i == 7));
         chk("bs_cout", 32'(co1), (i == 7) ? 32'd1 : 32'd0);
         chk("bs_ovf", 32'(of1), 32'd0);
      end
      @(posedge clk); #1;
      chk("bs_out_valid_after", 32'(ov1), 32'd0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
